// File: rtl/cnn_pkg.sv
// Shared types, constants and FSM encoding for the CNN streaming front end.
package cnn_pkg;

    localparam int MAX_FMAP = 32;
    localparam int KERNEL   = 5;

    typedef logic signed [15:0] pixel_t;
    typedef pixel_t [KERNEL-1:0][KERNEL-1:0] window_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } wb_state_e;

    // Row index arithmetic modulo the K-row circular line store.
    function automatic logic [2:0] ring_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'(KERNEL)) begin
            sum = sum - 4'(KERNEL);
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out stream bundle. master = DMA source plus window consumer,
// slave = the window buffer.
interface conv_window_buffer_if #(
    parameter int DATA_W = 16,
    parameter int K      = 5
);
    logic                            pix_valid;
    logic                            pix_ready;
    logic [DATA_W-1:0]               pix_data;
    logic                            win_valid;
    logic                            win_ready;
    logic [K-1:0][K-1:0][DATA_W-1:0] win_data;
    logic [4:0]                      win_row;
    logic [4:0]                      win_col;

    modport master (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win_data, win_row, win_col
    );

    modport slave (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win_data, win_row, win_col
    );
endinterface

// File: rtl/line_buffer_row.sv
// One feature-map line of the sliding-window store; the same column is written
// and read, and the read returns the value held before this cycle's write.
module line_buffer_row #(
    parameter  int DATA_W = 16,
    parameter  int MAX_W  = 32,
    localparam int AW     = $clog2(MAX_W)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     col_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [MAX_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[col_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[col_i];
endmodule

// File: rtl/conv_window_buffer.sv
// Streaming 5x5 stride-1 window generator over a circular K-line store.
// Optional 2x2 stride-2 pooling windows when CONV_WINDOW_POOL_MODE_EN is defined.
//   state    | meaning
//   ST_IDLE  | waiting for frame_start
//   ST_RUN   | accepting pixels, emitting windows
//   ST_FLUSH | all pixels in, waiting for last window handshake
//   ST_DONE  | frame_done pulse
module conv_window_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = KERNEL,
    parameter int MAX_W  = MAX_FMAP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [5:0]           img_size,
`ifdef CONV_WINDOW_POOL_MODE_EN
    input  logic                 pool_mode,
`endif
    output logic                 frame_done,
    conv_window_buffer_if.slave  bus
);
    typedef logic [K-1:0][K-1:0][DATA_W-1:0] win_t;

    wb_state_e   st_q, st_d;
    logic [5:0]  n_q, n_req, n_min;
    logic [4:0]  r_q, c_q;
    logic [2:0]  wr_row_q;
    logic        pool_en;
    logic        accept, last_col, last_row;

    logic [K-1:0][DATA_W-1:0] rd_data;
    win_t        col_q, col_d, win_new, win_data_q;
    logic        win_hit, win_valid_q;
    logic [4:0]  row_new, col_new, win_row_q, win_col_q;

`ifdef CONV_WINDOW_POOL_MODE_EN
    logic pool_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_q <= 1'b0;
        end else if (frame_start) begin
            pool_q <= pool_mode;
        end
    end
    assign pool_en = pool_q;
    assign n_min   = pool_mode ? 6'd2 : 6'(K);
`else
    assign pool_en = 1'b0;
    assign n_min   = 6'(K);
`endif

    always_comb begin
        n_req = img_size;
        if (img_size < n_min) begin
            n_req = n_min;
        end else if (img_size > 6'(MAX_W)) begin
            n_req = 6'(MAX_W);
        end
    end

    assign accept   = bus.pix_valid && bus.pix_ready;
    assign last_col = ({1'b0, c_q} == n_q - 6'd1);
    assign last_row = ({1'b0, r_q} == n_q - 6'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  if (frame_start) st_d = ST_RUN;
            ST_RUN:   if (accept && last_col && last_row) st_d = ST_FLUSH;
            ST_FLUSH: if (!win_valid_q || bus.win_ready) st_d = ST_DONE;
            ST_DONE:  st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
        // A new frame_start aborts whatever is in flight.
        if (frame_start) begin
            st_d = ST_RUN;
        end
    end

    always_comb begin
        bus.pix_ready = 1'b0;
        frame_done    = 1'b0;
        if (st_q == ST_RUN) begin
            bus.pix_ready = !frame_start && (!win_valid_q || bus.win_ready);
        end
        if (st_q == ST_DONE) begin
            frame_done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q      <= 6'(K);
            r_q      <= '0;
            c_q      <= '0;
            wr_row_q <= '0;
        end else if (frame_start) begin
            n_q      <= n_req;
            r_q      <= '0;
            c_q      <= '0;
            wr_row_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                c_q      <= '0;
                r_q      <= r_q + 5'd1;
                wr_row_q <= ring_add(wr_row_q, 3'd1);
            end else begin
                c_q <= c_q + 5'd1;
            end
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_row
        line_buffer_row #(.DATA_W(DATA_W), .MAX_W(MAX_W)) u_row (
            .clk     (clk),
            .we_i    (accept && (wr_row_q == 3'(k))),
            .col_i   (c_q),
            .wdata_i (bus.pix_data),
            .rdata_o (rd_data[k])
        );
    end

    // col_q holds the last K columns of rows r-4..r; the bottom row comes straight from the input.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                col_d[i][j] = col_q[i][j+1];
            end
            col_d[i][K-1] = (i == K - 1) ? bus.pix_data : rd_data[ring_add(wr_row_q, 3'(i + 1))];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            col_q <= col_d;
        end
    end

    always_comb begin
        win_hit = accept && (r_q >= 5'(K - 1)) && (c_q >= 5'(K - 1));
        win_new = col_d;
        row_new = r_q - 5'(K - 1);
        col_new = c_q - 5'(K - 1);
        if (pool_en) begin
            win_hit       = accept && r_q[0] && c_q[0];
            win_new       = '0;
            win_new[0][0] = col_d[K-2][K-2];
            win_new[0][1] = col_d[K-2][K-1];
            win_new[1][0] = col_d[K-1][K-2];
            win_new[1][1] = col_d[K-1][K-1];
            row_new       = r_q - 5'd1;
            col_new       = c_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else if (frame_start) begin
            win_valid_q <= 1'b0;
        end else if (win_hit) begin
            win_valid_q <= 1'b1;
            win_data_q  <= win_new;
            win_row_q   <= row_new;
            win_col_q   <= col_new;
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
endmodule
